mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: N, default 32, data and address width of both requester ports and the memory port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 req0, req1  input  1 each  access request from port 0 (instruction fetch) and port 1 (load/store).
REQ-005 we0, we1  input  1 each  write request qualifier, 1 = store, 0 = load.
REQ-006 addr0, addr1  input  N each  word address.
REQ-007 wdata0, wdata1  input  N each  store data.
REQ-008 done0, done1  output  1 each  one-cycle completion pulse per port.
REQ-009 rdata  output  N  registered load data, valid in the done cycle.
REQ-010 busy  output  1  high while a transaction is in flight (ACCESS or DONE).
REQ-011 mem_address, mem_data_in  output  N each  drive the data memory's address and write-data inputs.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_data_out  input  N  memory read data, combinational from mem_address.

Function
REQ-014 FSM states IDLE, ACCESS, DONE: IDLE->ACCESS when req0|req1; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-015 In IDLE with a request, the arbiter latches the winner's addr, wdata, we and port id on the same edge that enters ACCESS.
REQ-016 mem_address and mem_data_in come from latched registers only, never combinationally from requester inputs.
REQ-017 mem_we is high only in ACCESS with latched we=1, so exactly one memory write per store.
REQ-018 On the ACCESS->DONE edge, rdata captures mem_data_out for loads; on stores rdata holds its previous value.
REQ-019 In DONE, only the winning port's done pulses high, for exactly one cycle.
REQ-020 Latency: request seen in IDLE at edge t, done high in cycle t+2; minimum spacing between transactions is 3 cycles.
REQ-021 Requesters hold req, addr, we and wdata stable until done.
REQ-022 Deasserting req after the grant edge does not abort the transaction; it completes normally.
REQ-023 req still high in the DONE cycle is a new request, arbitrated in the following IDLE.
REQ-024 Arbitration is round-robin: with both requesting, the port not granted last wins; a lone requester always wins.
REQ-025 The last-grant pointer updates only when a grant occurs.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 On reset, the FSM goes to IDLE, regardless of state, and the in-flight transaction is dropped with no done pulse.
REQ-028 Reset values: done0 = done1 = 0, mem_we = 0, busy = 0, rdata = 0, mem_address = 0, mem_data_in = 0.
REQ-029 Reset sets the last-grant pointer to port 1, so port 0 wins the first contended arbitration.
REQ-030 A reset asserted during ACCESS with we=1 still leaves mem_we = 0 from the reset edge onward.

Configuration
REQ-031 Macro ARB_FIXED_PRIO_EN: when defined, port 0 always wins contention and the last-grant pointer is not implemented.
REQ-032 When ARB_FIXED_PRIO_EN is undefined, arbitration is round-robin per REQ-024.
REQ-033 All other behaviour is identical with and without ARB_FIXED_PRIO_EN.

Verification
REQ-034 Memory preloaded with word[3] = 4; req0 load from addr 3 -> mem_address = 3 in ACCESS, done0 at t+2, rdata = 4, done1 stays 0.
REQ-035 req1 store wdata = 0xA5 to addr 7, then req0 load from addr 7 -> mem_we high for exactly one cycle, then rdata = 0xA5.
REQ-036 req0 and req1 held high together for 4 transactions -> grants alternate 0,1,0,1 (round-robin build); 0,0,0,0 with ARB_FIXED_PRIO_EN.
REQ-037 Reset asserted during ACCESS of a store to addr 2 -> no done pulse, mem_we = 0 from the reset edge, word[2] unchanged, busy = 0.
REQ-038 req1 dropped one cycle after the grant edge -> done1 still pulses at t+2; no second transaction starts.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester, completion and data-memory signals of the two-port memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the requesters plus the data memory.
interface arb_if #(
    parameter int unsigned N = 32
);
    logic         req0;
    logic         req1;
    logic         we0;
    logic         we1;
    logic [N-1:0] addr0;
    logic [N-1:0] addr1;
    logic [N-1:0] wdata0;
    logic [N-1:0] wdata1;
    logic         done0;
    logic         done1;
    logic [N-1:0] rdata;
    logic         busy;
    logic [N-1:0] mem_address;
    logic [N-1:0] mem_data_in;
    logic         mem_we;
    logic [N-1:0] mem_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        output done0, done1, rdata, busy, mem_address, mem_data_in, mem_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
        input  done0, done1, rdata, busy, mem_address, mem_data_in, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. Port 0 is instruction fetch and port 1 is load/store.
// It shares one single-cycle data memory between the two ports.
// Each transaction takes three cycles: IDLE (grant), ACCESS (memory cycle) and
// DONE (completion pulse).
// Optional macro ARB_FIXED_PRIO_EN: when it is defined, port 0 always wins
// contention and there is no last-grant pointer. When it is undefined,
// arbitration is round-robin.
module mem_arbiter #(
    parameter int unsigned N = 32
) (
    input  logic  clk,
    input  logic  reset,
    arb_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         port_q, port_d;
    logic         we_q, we_d;
    logic [N-1:0] mem_address_q, mem_address_d;
    logic [N-1:0] mem_data_in_q, mem_data_in_d;
    logic         mem_we_q, mem_we_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         done0_q, done0_d;
    logic         done1_q, done1_d;
    logic         busy_q, busy_d;
    logic         grant_port;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 wins whenever it requests.
    always_comb begin
        grant_port = 1'b0;
        if (!bus.req0) begin
            grant_port = 1'b1;
        end
    end
`else
    logic last_q, last_d;

    // Round-robin: under contention the port not granted last wins.
    always_comb begin
        grant_port = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_port = ~last_q;
        end else if (!bus.req0) begin
            grant_port = 1'b1;
        end
    end

    // The last-grant pointer moves only on a grant.
    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && (bus.req0 || bus.req1)) begin
            last_d = grant_port;
        end
    end

    // Last-grant pointer register. Reset points it at port 1 so that port 0
    // wins the first contended grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Next state and next value of every registered output.
    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        we_d          = we_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = 1'b0;
        rdata_d       = rdata_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = S_ACCESS;
                    port_d  = grant_port;
                    if (grant_port) begin
                        we_d          = bus.we1;
                        mem_address_d = bus.addr1;
                        mem_data_in_d = bus.wdata1;
                    end else begin
                        we_d          = bus.we0;
                        mem_address_d = bus.addr0;
                        mem_data_in_d = bus.wdata0;
                    end
                    // The write enable is high for the whole ACCESS cycle and
                    // for no other cycle.
                    mem_we_d = grant_port ? bus.we1 : bus.we0;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                if (!we_q) begin
                    rdata_d = bus.mem_data_out;
                end
                done0_d = ~port_q;
                done1_d = port_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers. Reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            port_q        <= 1'b0;
            we_q          <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
            rdata_q       <= '0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            we_q          <= we_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
            rdata_q       <= rdata_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.rdata       = rdata_q;
    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// It models a small word-addressed data memory with combinational read.
module tb_mem_arbiter;

    localparam int unsigned N = 32;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    arb_if #(.N(N)) bus ();

    mem_arbiter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: combinational read. Writes are ignored while system reset is held.
    logic [N-1:0] mem [0:31];

    assign bus.mem_data_out = mem[bus.mem_address[4:0]];

    always @(posedge clk) begin
        if (bus.mem_we && !reset) begin
            mem[bus.mem_address[4:0]] <= bus.mem_data_in;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] <= '0;
        end
        mem[2]  <= 32'h55;
        mem[3]  <= 32'd4;
        mem[10] <= 32'h111;
        mem[20] <= 32'h222;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step one rising edge, then sample on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic exp_port;

        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.we0    = 1'b0;
        bus.we1    = 1'b0;
        bus.addr0  = '0;
        bus.addr1  = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        @(negedge clk);
        tick();
        tick();

        // Reset values.
        check("rst_done0", N'(bus.done0), N'(0));
        check("rst_done1", N'(bus.done1), N'(0));
        check("rst_mem_we", N'(bus.mem_we), N'(0));
        check("rst_busy", N'(bus.busy), N'(0));
        check("rst_rdata", bus.rdata, N'(0));
        check("rst_mem_address", bus.mem_address, N'(0));
        check("rst_mem_data_in", bus.mem_data_in, N'(0));

        // Port 0 load from address 3, which holds 4.
        reset     = 1'b0;
        bus.req0  = 1'b1;
        bus.we0   = 1'b0;
        bus.addr0 = 32'd3;
        tick();
        check("ld_access_busy", N'(bus.busy), N'(1));
        check("ld_access_addr", bus.mem_address, N'(3));
        check("ld_access_we", N'(bus.mem_we), N'(0));
        check("ld_access_done0", N'(bus.done0), N'(0));
        tick();
        check("ld_done0", N'(bus.done0), N'(1));
        check("ld_done1", N'(bus.done1), N'(0));
        check("ld_rdata", bus.rdata, N'(4));
        bus.req0 = 1'b0;
        tick();
        check("ld_idle_busy", N'(bus.busy), N'(0));
        check("ld_idle_done0", N'(bus.done0), N'(0));

        // Port 1 store of 0xA5 to address 7.
        bus.req1   = 1'b1;
        bus.we1    = 1'b1;
        bus.addr1  = 32'd7;
        bus.wdata1 = 32'hA5;
        tick();
        check("st_access_we", N'(bus.mem_we), N'(1));
        check("st_access_addr", bus.mem_address, N'(7));
        check("st_access_wdata", bus.mem_data_in, N'(32'hA5));
        tick();
        check("st_done1", N'(bus.done1), N'(1));
        check("st_done0", N'(bus.done0), N'(0));
        check("st_done_we", N'(bus.mem_we), N'(0));
        check("st_rdata_hold", bus.rdata, N'(4));
        bus.req1 = 1'b0;
        bus.we1  = 1'b0;
        tick();
        check("st_idle_we", N'(bus.mem_we), N'(0));
        check("st_mem7", mem[7], N'(32'hA5));

        // Port 0 load of the value that was just stored.
        bus.req0  = 1'b1;
        bus.addr0 = 32'd7;
        tick();
        tick();
        check("ldst_done0", N'(bus.done0), N'(1));
        check("ldst_rdata", bus.rdata, N'(32'hA5));
        bus.req0 = 1'b0;
        tick();

        // Both ports request continuously, starting from a freshly reset pointer.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        bus.req0  = 1'b1;
        bus.we0   = 1'b0;
        bus.addr0 = 32'd10;
        bus.req1  = 1'b1;
        bus.we1   = 1'b0;
        bus.addr1 = 32'd20;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp_port = 1'b0;
`else
            exp_port = (k % 2) == 1;
`endif
            tick();
            check($sformatf("rr%0d_addr", k), bus.mem_address, exp_port ? N'(20) : N'(10));
            tick();
            check($sformatf("rr%0d_done0", k), N'(bus.done0), N'(!exp_port));
            check($sformatf("rr%0d_done1", k), N'(bus.done1), N'(exp_port));
            check($sformatf("rr%0d_rdata", k), bus.rdata, exp_port ? N'(32'h222) : N'(32'h111));
            tick();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();

        // Reset during the ACCESS cycle of a store to address 2.
        bus.req0   = 1'b1;
        bus.we0    = 1'b1;
        bus.addr0  = 32'd2;
        bus.wdata0 = 32'h99;
        tick();
        check("rstacc_we_before", N'(bus.mem_we), N'(1));
        reset    = 1'b1;
        bus.req0 = 1'b0;
        bus.we0  = 1'b0;
        tick();
        check("rstacc_we", N'(bus.mem_we), N'(0));
        check("rstacc_busy", N'(bus.busy), N'(0));
        check("rstacc_done0", N'(bus.done0), N'(0));
        reset = 1'b0;
        tick();
        check("rstacc_done0_after", N'(bus.done0), N'(0));
        check("rstacc_mem2", mem[2], N'(32'h55));

        // Port 1 drops its request one cycle after the grant edge.
        bus.req1  = 1'b1;
        bus.we1   = 1'b0;
        bus.addr1 = 32'd20;
        tick();
        bus.req1 = 1'b0;
        check("drop_access_busy", N'(bus.busy), N'(1));
        tick();
        check("drop_done1", N'(bus.done1), N'(1));
        check("drop_rdata", bus.rdata, N'(32'h222));
        tick();
        check("drop_idle_busy", N'(bus.busy), N'(0));
        tick();
        check("drop_no_restart", N'(bus.busy), N'(0));
        check("drop_done1_low", N'(bus.done1), N'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
